sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Single-clock, parametrised FIFO: storage array, pointer control, status flags and error reporting in one block. Successor to the two-clock FIFO memory/controller pair, for buffering paths that live entirely inside one clock domain (e.g. register-file to ALU, UART TX staging). It adds occupancy count, programmable almost-full and almost-empty thresholds, a selectable registered read port, and sticky overflow and underflow flags.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry
- DEPTH, 8, number of entries; power of two, ≥ 2
- AF_LEVEL, DEPTH-2, walmost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1, ralmost_empty asserts when count ≤ AE_LEVEL
- OUT_REG, 0, read mode: 0 = show-ahead (combinational rdata), 1 = registered (1-cycle latency)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- winc  in  1  write request
- wdata  in  DATA_WIDTH  write data
- wfull  out  1  FIFO full
- walmost_full  out  1  count ≥ AF_LEVEL
- rinc  in  1  read request
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata valid: OUT_REG=1 only; tied to !rempty when OUT_REG=0
- rempty  out  1  FIFO empty
- ralmost_empty  out  1  count ≤ AE_LEVEL
- count  out  AW+1  occupancy, 0..DEPTH (AW = log2(DEPTH))
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wptr and rptr are AW+1 bits wide; the low AW bits address the array; the MSB is the wrap bit.
- Empty when wptr == rptr. Full when MSBs differ and the low bits are equal. count = wptr − rptr, modulo 2^(AW+1).
- Write accept: wa = winc & !wfull. On wa: mem[wptr[AW-1:0]] ← wdata, then wptr + 1.
- Read accept: ra = rinc & !rempty. On ra: rptr + 1.
- Acceptance uses the flags as they stand at the start of the cycle:
  - full with winc & rinc: read only; write is dropped and overflow is set.
  - empty with winc & rinc: write only; underflow is set.
- Neither pointer nor count changes on a rejected request.
- OUT_REG=0: rdata = mem[rptr[AW-1:0]] combinationally. rdata is don't-care while empty.
- OUT_REG=1: on ra, rdata ← mem[rptr] and rvalid = 1 in the next cycle. Otherwise rvalid = 0 and rdata holds its last value.
- Wrap-around: pointers roll over naturally; no special case at DEPTH-1 → 0.
- overflow and underflow are cleared only by rst.

## Timing
- Reset (rst high at an edge) puts every state element into a defined state:
  - wptr = rptr = 0, count = 0
  - all mem entries = 0, rdata = 0, rvalid = 0
  - rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0 (for AF_LEVEL > 0)
  - overflow = underflow = 0
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored.
- All flags and count are registered or derived from registered pointers. They update in the cycle after the accepted operation.
- Write-to-read latency: data written at edge N is readable (rempty = 0) after edge N.
  - OUT_REG=0: rdata is valid in that same cycle.
  - OUT_REG=1: rvalid pulses 1 cycle after the rinc that accepts it.
- Throughput: one write and one read per cycle, sustained.
- Simultaneous accepted read and write leave count and all flags unchanged.

## Structure
- Package fifo_pkg holds:
  - a clog2 function
  - the AW derivation
  - a parameter-legality check (DEPTH a power of two; AE_LEVEL < AF_LEVEL ≤ DEPTH)
- Sub-module fifo_mem: DEPTH × DATA_WIDTH array with one write port, clocked and enabled by wa with synchronous clear on rst, and one asynchronous read port.
- sync_fifo_ctrl owns the pointers, flags, the OUT_REG output stage and the error flags.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
- Reset: pulse rst with FIFO half full → next cycle count=0, rempty=1, wfull=0, overflow=0, rdata=0.
- Fill: write 0x01..0x08 in consecutive cycles → walmost_full rises after the 6th write, wfull after the 8th, count=8. A 9th write (0xFF) sets overflow, count stays 8, and the FIFO later reads back 0x01..0x08.
- Drain: from full, read 8 times → data 0x01..0x08 in order, ralmost_empty rises when count=1, rempty when count=0. A 9th rinc sets underflow and rptr is unchanged.
- Simultaneous: at count=3, hold winc & rinc for 20 cycles with an incrementing pattern → count stays 3, data in order, pointers wrap at least twice.
- Boundary simultaneous:
  - full with winc & rinc → count becomes 7, overflow = 1.
  - empty with winc & rinc → count becomes 1, underflow = 1.
- OUT_REG=1: write 0xA5, then rinc → rvalid=1 with rdata=0xA5 exactly one cycle later, and rvalid=0 on the following cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: address-width derivation,
// parameter legality check and small common types.
package fifo_pkg;

  // Read-port modes selected by OUT_REG.
  localparam int MODE_SHOW_AHEAD = 0;
  localparam int MODE_REGISTERED = 1;

  // Sticky error flags, kept together so they reset and update as one unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Ceiling log2 with a bounded loop so it stays elaboration friendly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Address width used for the array; pointers carry one extra wrap bit.
  function automatic int calc_aw(input int depth);
    return clog2(depth);
  endfunction

  // DEPTH must be a power of two >= 2 and the thresholds must be ordered.
  function automatic bit params_legal(input int depth, input int af_level,
                                      input int ae_level, input int out_reg);
    bit ok;
    ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
    ok = ok && (ae_level < af_level) && (af_level <= depth);
    ok = ok && ((out_reg == MODE_SHOW_AHEAD) || (out_reg == MODE_REGISTERED));
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Bus bundle for sync_fifo_ctrl. The master side (producer/consumer logic)
// drives requests and write data; the slave side (the FIFO) drives data,
// flags, occupancy and error status.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  import fifo_pkg::*;

  localparam int AW = calc_aw(DEPTH);

  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one clocked write port with synchronous clear,
// one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear every entry on reset so stale data never appears on rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointer control, status flags, occupancy count,
// selectable show-ahead or registered read port, sticky error flags.
//
// Handshake: winc is a write request and !wfull is its ready; a write is
// accepted (wa) only when both are high in the same cycle. rinc is a read
// request and !rempty is its ready; a read is accepted (ra) only when both
// are high. Ready is taken from the flags as they stand at the start of the
// cycle, so a full FIFO drops a same-cycle write even while it is being read,
// and an empty FIFO rejects a same-cycle read even while it is being written.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1,
  parameter int OUT_REG    = 0
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_ctrl_if.slave   bus
);

  localparam int AW = calc_aw(DEPTH);

  // Thresholds narrowed to the count width; AF_LEVEL may equal DEPTH.
  localparam logic [AW:0] AF_TH = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_TH = AE_LEVEL[AW:0];

  if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL, OUT_REG)) begin : g_bad_params
    $error("sync_fifo_ctrl: illegal DEPTH/AF_LEVEL/AE_LEVEL/OUT_REG combination");
  end

  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  wa;
  logic                  ra;
  fifo_err_t             err_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags and count derive only from registered pointers, so they move in
  // the cycle after an accepted operation and stay put when wa and ra match.
  always_comb begin
    count = wptr - rptr;
    empty = (wptr == rptr);
    full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    wa    = bus.winc && !full;
    ra    = bus.rinc && !empty;
  end

  // Write pointer: advances on every accepted write, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
    end else if (wa) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Read pointer: advances on every accepted read, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
    end else if (ra) begin
      rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags: set by any rejected request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q.overflow  <= err_q.overflow  | (bus.winc & full);
      err_q.underflow <= err_q.underflow | (bus.rinc & empty);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wa),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  if (OUT_REG == MODE_REGISTERED) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // Capture the head entry on an accepted read; rvalid pulses one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= ra;
        if (ra) begin
          rdata_q <= mem_rdata;
        end
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end else begin : g_show_ahead
    // Head entry is visible whenever the FIFO is not empty.
    assign bus.rdata  = mem_rdata;
    assign bus.rvalid = !empty;
  end

  assign bus.count         = count;
  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (count >= AF_TH);
  assign bus.ralmost_empty = (count <= AE_TH);
  assign bus.overflow      = err_q.overflow;
  assign bus.underflow     = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one show-ahead instance and one
// registered-read instance sharing clock and reset.
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_a ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_b ();

  sync_fifo_ctrl #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .OUT_REG (0)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .OUT_REG (1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.winc  = 1'b0;
    bus_a.rinc  = 1'b0;
    bus_a.wdata = '0;
    bus_b.winc  = 1'b0;
    bus_b.rinc  = 1'b0;
    bus_b.wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_a(input logic [DW-1:0] d);
    bus_a.winc  = 1'b1;
    bus_a.rinc  = 1'b0;
    bus_a.wdata = d;
    step();
    bus_a.winc  = 1'b0;
    exp_q.push_back(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] head;

    rst = 1'b1;
    idle_all();
    step();
    step();

    // Reset state of both instances.
    check_eq("rst_count",  bus_a.count, 0);
    check_eq("rst_rempty", bus_a.rempty, 1);
    check_eq("rst_rae",    bus_a.ralmost_empty, 1);
    check_eq("rst_wfull",  bus_a.wfull, 0);
    check_eq("rst_waf",    bus_a.walmost_full, 0);
    check_eq("rst_ovf",    bus_a.overflow, 0);
    check_eq("rst_udf",    bus_a.underflow, 0);
    check_eq("rst_rdata",  bus_a.rdata, 0);
    check_eq("rst_b_rvalid", bus_b.rvalid, 0);
    check_eq("rst_b_rdata",  bus_b.rdata, 0);
    rst = 1'b0;

    // Reset with the FIFO half full, with a write request in the reset cycle.
    for (int i = 0; i < 4; i++) write_a(8'h10 + 8'(i));
    check_eq("half_count", bus_a.count, 4);
    check_eq("half_rdata", bus_a.rdata, 8'h10);
    rst = 1'b1;
    bus_a.winc  = 1'b1;
    bus_a.wdata = 8'h77;
    step();
    rst = 1'b0;
    bus_a.winc = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_count",  bus_a.count, 0);
    check_eq("mid_rst_rempty", bus_a.rempty, 1);
    check_eq("mid_rst_wfull",  bus_a.wfull, 0);
    check_eq("mid_rst_ovf",    bus_a.overflow, 0);
    check_eq("mid_rst_rdata",  bus_a.rdata, 0);
    step();
    check_eq("rst_write_ignored", bus_a.count, 0);

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      write_a(8'(i));
      check_eq("fill_count", bus_a.count, i);
      check_eq("fill_waf",   bus_a.walmost_full, (i >= 6) ? 1 : 0);
      check_eq("fill_wfull", bus_a.wfull, (i == 8) ? 1 : 0);
      check_eq("fill_rempty", bus_a.rempty, 0);
      check_eq("fill_head",  bus_a.rdata, 8'h01);
    end
    // 9th write while full is dropped.
    bus_a.winc  = 1'b1;
    bus_a.wdata = 8'hFF;
    step();
    bus_a.winc = 1'b0;
    check_eq("ovf_set",   bus_a.overflow, 1);
    check_eq("ovf_count", bus_a.count, 8);
    check_eq("ovf_wfull", bus_a.wfull, 1);

    // Drain: expect 0x01..0x08 in order.
    for (int i = 0; i < 8; i++) begin
      bus_a.rinc = 1'b1;
      head = exp_q.pop_front();
      check_eq("drain_data", bus_a.rdata, head);
      step();
      check_eq("drain_count", bus_a.count, 7 - i);
      check_eq("drain_rae",   bus_a.ralmost_empty, ((7 - i) <= 1) ? 1 : 0);
      check_eq("drain_rempty", bus_a.rempty, ((7 - i) == 0) ? 1 : 0);
      check_eq("drain_waf",   bus_a.walmost_full, ((7 - i) >= 6) ? 1 : 0);
    end
    // 9th read while empty is rejected.
    step();
    bus_a.rinc = 1'b0;
    check_eq("udf_set",    bus_a.underflow, 1);
    check_eq("udf_count",  bus_a.count, 0);
    check_eq("udf_rempty", bus_a.rempty, 1);
    check_eq("udf_ovf_sticky", bus_a.overflow, 1);
    // Read pointer must not have moved: a fresh write is the new head.
    write_a(8'h11);
    check_eq("udf_ptr_count", bus_a.count, 1);
    check_eq("udf_ptr_rdata", bus_a.rdata, 8'h11);

    // Simultaneous read and write at count=3 for 20 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) write_a(8'h20 + 8'(i));
    for (int k = 0; k < 20; k++) begin
      bus_a.winc  = 1'b1;
      bus_a.rinc  = 1'b1;
      bus_a.wdata = 8'h40 + 8'(k);
      head = exp_q.pop_front();
      check_eq("sim_data", bus_a.rdata, head);
      exp_q.push_back(8'h40 + 8'(k));
      step();
      check_eq("sim_count", bus_a.count, 3);
    end
    idle_all();
    for (int i = 0; i < 3; i++) begin
      bus_a.rinc = 1'b1;
      head = exp_q.pop_front();
      check_eq("sim_tail", bus_a.rdata, head);
      step();
    end
    bus_a.rinc = 1'b0;
    check_eq("sim_empty", bus_a.rempty, 1);
    check_eq("sim_no_err", {bus_a.overflow, bus_a.underflow}, 0);

    // Full with winc & rinc: read only, overflow set.
    do_reset();
    for (int i = 0; i < 8; i++) write_a(8'h30 + 8'(i));
    bus_a.winc  = 1'b1;
    bus_a.rinc  = 1'b1;
    bus_a.wdata = 8'h99;
    step();
    idle_all();
    check_eq("bfull_count", bus_a.count, 7);
    check_eq("bfull_ovf",   bus_a.overflow, 1);
    check_eq("bfull_wfull", bus_a.wfull, 0);
    check_eq("bfull_head",  bus_a.rdata, 8'h31);

    // Empty with winc & rinc: write only, underflow set.
    do_reset();
    bus_a.winc  = 1'b1;
    bus_a.rinc  = 1'b1;
    bus_a.wdata = 8'h55;
    step();
    idle_all();
    check_eq("bempty_count",  bus_a.count, 1);
    check_eq("bempty_udf",    bus_a.underflow, 1);
    check_eq("bempty_ovf",    bus_a.overflow, 0);
    check_eq("bempty_rempty", bus_a.rempty, 0);
    check_eq("bempty_rvalid", bus_a.rvalid, 1);
    check_eq("bempty_head",   bus_a.rdata, 8'h55);

    // Registered read port.
    bus_b.winc  = 1'b1;
    bus_b.wdata = 8'hA5;
    step();
    bus_b.winc = 1'b0;
    check_eq("oreg_pre_rvalid", bus_b.rvalid, 0);
    check_eq("oreg_pre_rempty", bus_b.rempty, 0);
    bus_b.rinc = 1'b1;
    step();
    bus_b.rinc = 1'b0;
    check_eq("oreg_rvalid", bus_b.rvalid, 1);
    check_eq("oreg_rdata",  bus_b.rdata, 8'hA5);
    step();
    check_eq("oreg_rvalid_drop", bus_b.rvalid, 0);
    check_eq("oreg_rdata_hold",  bus_b.rdata, 8'hA5);
    check_eq("oreg_rempty",      bus_b.rempty, 1);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
